// File: rtl/controlador_sequenciador_pkg.sv
// Shared constants for the SAP-1 style controller-sequencer: opcodes, control-word
// bit positions, the inactive control word and the one-hot timing states.
package controlador_sequenciador_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int CP   = 11;
  localparam int EP   = 10;
  localparam int N_LM = 9;
  localparam int N_CE = 8;
  localparam int N_LI = 7;
  localparam int N_EI = 6;
  localparam int N_LA = 5;
  localparam int EA   = 4;
  localparam int SU   = 3;
  localparam int EU   = 2;
  localparam int N_LB = 1;
  localparam int N_LO = 0;

  // Active-high bits low, n_-prefixed bits high: nothing drives or loads.
  localparam logic [11:0] CON_INACTIVE = 12'b0011_1110_0011;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

endpackage

// File: rtl/controlador_sequenciador_contador_anel.sv
// Six-state one-hot ring counter T1..T6, clocked on the falling edge,
// with synchronous reset to T1 and a hold input used for halt.
module contador_anel
  import controlador_sequenciador_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [5:0] t
);

  logic [5:0] t_q;
  logic [5:0] t_d;

  // Reset wins over hold, hold wins over rotation.
  always_comb begin
    t_d = {t_q[4:0], t_q[5]};
    if (rst) begin
      t_d = T1;
    end else if (hold) begin
      t_d = t_q;
    end
  end

  always_ff @(negedge clk) begin
    t_q <= t_d;
  end

  assign t = t_q;

endmodule

// File: rtl/controlador_sequenciador.sv
// Controller-sequencer: ring counter plus combinational control-word decode.
// Define HLT_EN to decode opcode 1111 as HLT (sticky halt, frozen at T4).
module controlador_sequenciador
  import controlador_sequenciador_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t,
  output logic        hlt
);

  logic        hold;
  logic [11:0] con_dec;

`ifdef HLT_EN
  logic hlt_q;
  logic hlt_d;
  logic hlt_set;

  assign hlt_set = (t == T4) && (opcode == OP_HLT);

  always_comb begin
    hlt_d = hlt_q | hlt_set;
    if (rst) begin
      hlt_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    hlt_q <= hlt_d;
  end

  // Freeze on the same edge that raises hlt so t stays at T4.
  assign hold = hlt_q | hlt_set;
  assign hlt  = hlt_q;
`else
  assign hold = 1'b0;
  assign hlt  = 1'b0;
`endif

  contador_anel u_contador_anel (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .t    (t)
  );

  always_comb begin
    con_dec = CON_INACTIVE;
    case (t)
      T1: begin
        con_dec[EP]   = 1'b1;
        con_dec[N_LM] = 1'b0;
      end
      T2: con_dec[CP] = 1'b1;
      T3: begin
        con_dec[N_CE] = 1'b0;
        con_dec[N_LI] = 1'b0;
      end
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            con_dec[N_LM] = 1'b0;
            con_dec[N_EI] = 1'b0;
          end
          OP_OUT: begin
            con_dec[EA]   = 1'b1;
            con_dec[N_LO] = 1'b0;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA: begin
            con_dec[N_CE] = 1'b0;
            con_dec[N_LA] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            con_dec[N_CE] = 1'b0;
            con_dec[N_LB] = 1'b0;
          end
          default: ;
        endcase
      end
      T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          con_dec[EU]   = 1'b1;
          con_dec[N_LA] = 1'b0;
          con_dec[SU]   = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
    // Nothing may load while in reset or halted.
    if (rst || hlt) begin
      con_dec = CON_INACTIVE;
    end
  end

  assign con = con_dec;

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Scoreboard bench for controlador_sequenciador: stimulus queues expected t/con/hlt
// per half-cycle window; a monitor on the rising edge pops and compares.
module tb_controlador_sequenciador;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = 4'b0000;
  logic [11:0] con;
  logic [5:0]  t;
  logic        hlt;

  typedef struct {
    string       nm;
    logic [5:0]  t;
    logic [11:0] con;
    logic        hlt;
  } exp_s;

  exp_s sb[$];
  int   vectors = 0;
  int   miss    = 0;

  localparam logic [11:0] INA = 12'h3E3;

  controlador_sequenciador dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .con    (con),
    .t      (t),
    .hlt    (hlt)
  );

  always #5 clk = ~clk;

  // Monitor: sample away from the active (falling) edge.
  always @(posedge clk) begin
    if (sb.size() != 0) begin
      exp_s e;
      e = sb.pop_front();
      vectors++;
      if (t !== e.t || con !== e.con || hlt !== e.hlt) begin
        miss++;
        $display("FAIL %s: got t=%b con=%h hlt=%b, expected t=%b con=%h hlt=%b",
                 e.nm, t, con, hlt, e.t, e.con, e.hlt);
      end
    end
  end

  // W-bus drivers: ep, ~n_ce, ~n_ei, ea, eu -- at most one at a time.
  always @(posedge clk) begin
    int drivers;
    drivers = int'(con[10]) + int'(!con[8]) + int'(!con[6]) + int'(con[4]) + int'(con[2]);
    assert (drivers <= 1)
    else begin
      miss++;
      $display("FAIL bus_excl: got %0d drivers con=%h t=%b opcode=%b, expected <=1",
               drivers, con, t, opcode);
    end
  end

  task automatic vec(input string nm, input logic r, input logic [3:0] op,
                     input logic [5:0] et, input logic [11:0] ec, input logic eh);
    @(negedge clk);
    #1;
    rst    = r;
    opcode = op;
    sb.push_back('{nm, et, ec, eh});
  endtask

  initial begin
    logic [11:0] fetch [3];
    fetch[0] = 12'h5E3;
    fetch[1] = 12'hBE3;
    fetch[2] = 12'h263;

    vec("reset",       1'b1, 4'h0, 6'h01, INA,    1'b0);
    // LDA
    vec("lda_t1",      1'b0, 4'h0, 6'h01, 12'h5E3, 1'b0);
    vec("lda_t2",      1'b0, 4'h0, 6'h02, 12'hBE3, 1'b0);
    vec("lda_t3",      1'b0, 4'h0, 6'h04, 12'h263, 1'b0);
    vec("lda_t4",      1'b0, 4'h0, 6'h08, 12'h1A3, 1'b0);
    vec("lda_t5",      1'b0, 4'h0, 6'h10, 12'h2C3, 1'b0);
    vec("lda_t6",      1'b0, 4'h0, 6'h20, INA,    1'b0);
    // ADD
    vec("add_t1",      1'b0, 4'h1, 6'h01, 12'h5E3, 1'b0);
    vec("add_t2",      1'b0, 4'h1, 6'h02, 12'hBE3, 1'b0);
    vec("add_t3",      1'b0, 4'h1, 6'h04, 12'h263, 1'b0);
    vec("add_t4",      1'b0, 4'h1, 6'h08, 12'h1A3, 1'b0);
    vec("add_t5",      1'b0, 4'h1, 6'h10, 12'h2E1, 1'b0);
    vec("add_t6",      1'b0, 4'h1, 6'h20, 12'h3C7, 1'b0);
    // SUB
    vec("sub_t1",      1'b0, 4'h2, 6'h01, 12'h5E3, 1'b0);
    vec("sub_t2",      1'b0, 4'h2, 6'h02, 12'hBE3, 1'b0);
    vec("sub_t3",      1'b0, 4'h2, 6'h04, 12'h263, 1'b0);
    vec("sub_t4",      1'b0, 4'h2, 6'h08, 12'h1A3, 1'b0);
    vec("sub_t5",      1'b0, 4'h2, 6'h10, 12'h2E1, 1'b0);
    vec("sub_t6",      1'b0, 4'h2, 6'h20, 12'h3CF, 1'b0);
    // OUT
    vec("out_t1",      1'b0, 4'hE, 6'h01, 12'h5E3, 1'b0);
    vec("out_t2",      1'b0, 4'hE, 6'h02, 12'hBE3, 1'b0);
    vec("out_t3",      1'b0, 4'hE, 6'h04, 12'h263, 1'b0);
    vec("out_t4",      1'b0, 4'hE, 6'h08, 12'h3F2, 1'b0);
    vec("out_t5",      1'b0, 4'hE, 6'h10, INA,    1'b0);
    vec("out_t6",      1'b0, 4'hE, 6'h20, INA,    1'b0);
    // Reset in the middle of ADD, at T5
    vec("addr_t1",     1'b0, 4'h1, 6'h01, 12'h5E3, 1'b0);
    vec("addr_t2",     1'b0, 4'h1, 6'h02, 12'hBE3, 1'b0);
    vec("addr_t3",     1'b0, 4'h1, 6'h04, 12'h263, 1'b0);
    vec("addr_t4",     1'b0, 4'h1, 6'h08, 12'h1A3, 1'b0);
    vec("addr_rst_t5", 1'b1, 4'h1, 6'h10, INA,    1'b0);
    vec("addr_post_t1",1'b0, 4'h1, 6'h01, 12'h5E3, 1'b0);
    vec("addr_post_t2",1'b0, 4'h1, 6'h02, 12'hBE3, 1'b0);
    vec("addr_post_t3",1'b0, 4'h1, 6'h04, 12'h263, 1'b0);
    vec("addr_post_t4",1'b0, 4'h1, 6'h08, 12'h1A3, 1'b0);
    vec("addr_post_t5",1'b0, 4'h1, 6'h10, 12'h2E1, 1'b0);
    vec("addr_post_t6",1'b0, 4'h1, 6'h20, 12'h3C7, 1'b0);
    // NOP opcodes 0011..1101: fetch then inactive
    for (int op = 3; op <= 13; op++) begin
      for (int k = 0; k < 6; k++) begin
        vec($sformatf("nop%0d_t%0d", op, k + 1), 1'b0, 4'(op), 6'(1 << k),
            (k < 3) ? fetch[k] : INA, 1'b0);
      end
    end
    // Opcode 1111
    vec("op15_t1",     1'b0, 4'hF, 6'h01, 12'h5E3, 1'b0);
    vec("op15_t2",     1'b0, 4'hF, 6'h02, 12'hBE3, 1'b0);
    vec("op15_t3",     1'b0, 4'hF, 6'h04, 12'h263, 1'b0);
    vec("op15_t4",     1'b0, 4'hF, 6'h08, INA,    1'b0);
`ifdef HLT_EN
    for (int i = 0; i < 10; i++) begin
      vec($sformatf("halted_%0d", i), 1'b0, 4'hF, 6'h08, INA, 1'b1);
    end
    vec("halt_rst",    1'b1, 4'hF, 6'h08, INA,    1'b1);
    vec("halt_clr_t1", 1'b0, 4'h0, 6'h01, 12'h5E3, 1'b0);
    vec("halt_clr_t2", 1'b0, 4'h0, 6'h02, 12'hBE3, 1'b0);
`else
    vec("op15_t5",     1'b0, 4'hF, 6'h10, INA,    1'b0);
    vec("op15_t6",     1'b0, 4'hF, 6'h20, INA,    1'b0);
    vec("op15_wrap",   1'b0, 4'h0, 6'h01, 12'h5E3, 1'b0);
`endif

    for (int i = 0; i < 5 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      miss++;
      $display("FAIL drain: got %0d entries pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
